// File: rtl/comb_inverse.sv
// comb_inverse: undoes the gain-1/2, feedback-7/8 comb filter of equal DEPTH.
// z[n] = SAT32(2*y[n] - 1.75*y[n-DEPTH]). The 1.75*d term is built as d + d/2 + d/4
// with floor shifts. The delay memory is zeroed word-by-word after reset and
// whenever processing is (re)enabled, so stale history never reaches the output.
module comb_inverse #(
  parameter int DEPTH = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [31:0] in,
  output logic signed [31:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               sat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_BYPASS = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      clr_addr_q, clr_addr_d;
  logic signed [31:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;

  // delay line; contents are never reset, CLEAR zeroes them instead
  logic signed [31:0] mem [DEPTH];
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic signed [31:0] mem_wdata;
  logic signed [31:0] d_rd;

  // datapath intermediates: 36 bits covers 2*in plus 1.75*d without wrap
  logic signed [35:0] in_x, d_x, acc;
  logic signed [31:0] acc_sat;
  logic               ovf_hi, ovf_lo;

  // the oldest sample sits at the address about to be overwritten
  assign d_rd = mem[addr_q];

  // inverse-comb arithmetic and 32-bit saturation
  always_comb begin
    in_x    = {{4{in[31]}}, in};
    d_x     = {{4{d_rd[31]}}, d_rd};
    acc     = (in_x <<< 1) - d_x - (d_x >>> 1) - (d_x >>> 2);
    ovf_hi  = !acc[35] && (acc[34:31] != 4'h0);
    ovf_lo  =  acc[35] && (acc[34:31] != 4'hF);
    acc_sat = acc[31:0];
    if (ovf_hi) acc_sat = 32'sh7FFF_FFFF;
    if (ovf_lo) acc_sat = 32'sh8000_0000;
  end

  // next-state, memory write and output decisions for the three modes
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    clr_addr_d  = clr_addr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sat_d       = 1'b0;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    mem_wdata   = in;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = 32'sd0;
        busy_d    = 1'b1;
        if (clr_addr_q == LAST) begin
          clr_addr_d = '0;
          addr_d     = '0;
          busy_d     = 1'b0;
          state_d    = enable ? S_RUN : S_BYPASS;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      S_BYPASS: begin
        out_valid_d = in_valid;
        if (in_valid) out_d = in;
        if (enable) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // leaving RUN drops the sample offered this cycle
          state_d = S_BYPASS;
          addr_d  = '0;
        end else if (in_valid) begin
          mem_we      = 1'b1;
          out_d       = acc_sat;
          sat_d       = ovf_hi || ovf_lo;
          out_valid_d = 1'b1;
          addr_d      = (addr_q == LAST) ? '0 : addr_q + AW'(1);
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
        busy_d     = 1'b1;
      end
    endcase
  end

  // control and output registers; reset restarts the clear sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      addr_q      <= '0;
      clr_addr_q  <= '0;
      out_q       <= 32'sd0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      clr_addr_q  <= clr_addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
    end
  end

  // delay memory write port; blocked while reset is held
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_comb_inverse.sv
// Bench for comb_inverse at DEPTH=4: directed vector table, hand-written
// bypass/reset sequences, random checks against a queue-based model and a
// cascade behind a behavioural comb filter.
module tb_comb_inverse;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset, enable, in_valid;
  logic signed [31:0] din, dout;
  logic out_valid, busy, sat;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  comb_inverse #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in(din), .out(dout), .out_valid(out_valid), .busy(busy), .sat(sat)
  );

  typedef struct {
    logic               en;
    logic               vld;
    logic signed [31:0] din;
    logic               exp_vld;
    logic signed [31:0] exp_out;
    logic               exp_sat;
  } vec_t;

  vec_t tbl [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // counts cycles busy stays high, starting from the current sample
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en; in_valid = tbl[i].vld; din = tbl[i].din;
      step();
      chk($sformatf("%s[%0d].vld", tag, i), out_valid, tbl[i].exp_vld);
      chk($sformatf("%s[%0d].out", tag, i), dout, tbl[i].exp_out);
      chk($sformatf("%s[%0d].sat", tag, i), sat, tbl[i].exp_sat);
    end
    in_valid = 1'b0;
  endtask

  function automatic longint fl(input longint a, input longint k);
    return (a - (((a % k) + k) % k)) / k;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic reset_and_clear();
    int n;
    reset = 1'b1; in_valid = 1'b0; enable = 1'b1;
    step();
    reset = 1'b0;
    busy_len(n);
  endtask

  initial begin
    int n;
    longint hist [$];
    longint xh [$];
    longint yh [$];
    longint prev, expv, d, x, y, xd, yd, err;
    logic signed [23:0] r24;
    logic ev;

    // impulse, hold, and saturation vectors from a freshly cleared state
    tbl[0]  = '{1'b1, 1'b1, 32'sd1000, 1'b1, 32'sd2000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'sd0, 1'b1, -32'sd1750, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'sd999, 1'b0, -32'sd1750, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 32'sh7FFF_FFFF, 1'b1, 32'sh7FFF_FFFF, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'sh8000_0000, 1'b1, 32'sh8000_0000, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sd0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sh8000_0000, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'sd0, 1'b1, 32'sh7FFF_FFFF, 1'b1};
    tbl[15] = '{1'b1, 1'b1, -32'sd3, 1'b1, -32'sd6, 1'b0};

    // reset wins over in_valid; clear lasts DEPTH cycles with no output
    reset = 1'b1; enable = 1'b1; in_valid = 1'b1; din = 32'sd123;
    step();
    chk("rst.busy", busy, 1); chk("rst.out", dout, 0);
    chk("rst.vld", out_valid, 0); chk("rst.sat", sat, 0);
    reset = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      chk("clr.vld", out_valid, 0);
      n++;
      step();
    end
    chk("clr.len", n, D);
    chk("clr.last_vld", out_valid, 0);
    in_valid = 1'b0;

    run_table("imp");

    // leaving RUN swallows that cycle's sample, then pass-through
    enable = 1'b0; in_valid = 1'b1; din = 32'sd77;
    step();
    chk("byx.vld", out_valid, 0); chk("byx.out", dout, -6);
    din = 32'sd5; step();
    chk("by5.vld", out_valid, 1); chk("by5.out", dout, 5); chk("by5.sat", sat, 0);
    in_valid = 1'b0; step();
    chk("bygap.vld", out_valid, 0); chk("bygap.out", dout, 5);
    in_valid = 1'b1; din = -32'sd7; step();
    chk("by-7.vld", out_valid, 1); chk("by-7.out", dout, -7); chk("by-7.sat", sat, 0);
    din = 32'sh7FFF_FFFF; step();
    chk("bymax.out", dout, 64'sd2147483647); chk("bymax.sat", sat, 0);
    in_valid = 1'b0; enable = 1'b1;
    step();
    busy_len(n);
    chk("reen.len", n, D);
    run_table("imp2");

    // reset mid-RUN, then again mid-CLEAR
    in_valid = 1'b1; din = 32'sd300; step();
    din = 32'sd400; step();
    reset = 1'b1; step();
    chk("rrun.out", dout, 0); chk("rrun.vld", out_valid, 0); chk("rrun.busy", busy, 1);
    reset = 1'b0; in_valid = 1'b0;
    step(); step();
    reset = 1'b1; step();
    reset = 1'b0;
    busy_len(n);
    chk("rclr.len", n, D);
    in_valid = 1'b1; din = 32'sd100; step();
    chk("r100.out", dout, 200);
    for (int i = 0; i < 3; i++) begin
      din = 32'sd0; step();
      chk("rzero.out", dout, 0);
    end
    din = 32'sd50; step();
    chk("r50.out", dout, -75);
    in_valid = 1'b0;

    // random stimulus against a queue model of the delay line
    reset_and_clear();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(0);
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: din = $signed($urandom_range(0, 2000)) - 32'sd1000;
        1: din = ($urandom_range(0, 1) != 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
        default: din = $signed($urandom);
      endcase
      ev = 1'b0;
      expv = prev;
      if (in_valid) begin
        d = hist.pop_front();
        x = din;
        hist.push_back(x);
        expv = clamp(2 * x - d - fl(d, 2) - fl(d, 4));
        ev = (2 * x - d - fl(d, 2) - fl(d, 4)) != expv;
      end
      step();
      chk("rnd.vld", out_valid, in_valid);
      chk("rnd.out", dout, expv);
      chk("rnd.sat", sat, ev);
      prev = expv;
    end
    in_valid = 1'b0;

    // cascade behind a behavioural comb: y = x[n-D]/2 + 7/8*y[n-D]
    reset_and_clear();
    xh.delete(); yh.delete();
    for (int i = 0; i < D; i++) begin xh.push_back(0); yh.push_back(0); end
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      xd = 0;
      if (in_valid) begin
        r24 = 24'($urandom);
        x = r24;
        xd = xh.pop_front();
        yd = yh.pop_front();
        y = fl(xd, 2) + fl(yd, 2) + fl(yd, 4) + fl(yd, 8);
        xh.push_back(x);
        yh.push_back(y);
        din = 32'(y);
      end else begin
        din = $signed($urandom);
      end
      step();
      if (in_valid) begin
        compared++;
        err = longint'(dout) - xd;
        if (!out_valid || err > 0 || err < -4) begin
          mismatched++;
          $display("FAIL cascade[%0d]: got out=%0d vld=%0d, required %0d-4..%0d vld=1", i, dout, out_valid, xd, xd);
        end
      end
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
